// File: rtl/conv_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the stream FIFO family.
package conv_fifo_pkg;

    localparam int unsigned FWFT_ON  = 1;
    localparam int unsigned FWFT_OFF = 0;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Legal configuration: power-of-two depth and ordered thresholds.
    function automatic bit cfg_ok(input int unsigned depth, input int unsigned ae_th,
                                  input int unsigned af_th);
        return is_pow2(depth) && (ae_th < af_th) && (af_th <= depth);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (read-first).
module fifo_sdp_ram
    import conv_fifo_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [W-1:0]              wr_data,
    input  logic                      re,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [W-1:0]              rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO with FWFT or legacy read, flags, flush and drop-on-full.
module stream_fifo
    import conv_fifo_pkg::*;
#(
    parameter int unsigned W            = 8,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned FWFT         = FWFT_ON,
    parameter int unsigned DROP_ON_FULL = 0,
    parameter int unsigned AF_TH        = DEPTH - 2,
    parameter int unsigned AE_TH        = 1,
    parameter int unsigned CW           = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [W-1:0]            s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [W-1:0]            m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ptr_w(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [CW-1:0]           drop_cnt
);

    localparam int unsigned PW   = ptr_w(DEPTH);
    localparam int unsigned CntW = PW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfC    = CntW'(AF_TH);
    localparam logic [CntW-1:0] AeC    = CntW'(AE_TH);

    if (!cfg_ok(DEPTH, AE_TH, AF_TH)) begin : g_bad_cfg
        $fatal(1, "stream_fifo: DEPTH must be a power of two and AE_TH < AF_TH <= DEPTH");
    end

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            m_valid_q, m_valid_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            push, pop, drop;
    logic            rd_en;
    logic [PW-1:0]   rd_addr;

    // Flags come straight from the registered count, never from this cycle's inputs.
    assign full         = (count_q == DepthC);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfC);
    assign almost_empty = (count_q <= AeC);

    assign s_ready = !rst && ((DROP_ON_FULL != 0) || !full);

    always_comb begin
        push = s_valid && !full && !rst && !flush;
        drop = (DROP_ON_FULL != 0) && s_valid && full && !rst && !flush;
        if (FWFT == FWFT_ON) begin
            pop = m_valid_q && m_ready && !rst && !flush;
        end else begin
            pop = m_ready && !empty && !rst && !flush;
        end

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        m_valid_d  = m_valid_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            m_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            // A word written at this edge cannot be read back until the next one, so the
            // head is only presentable if something older than this edge survives the pop.
            if (FWFT == FWFT_ON) begin
                m_valid_d = (count_q - CntW'(pop)) != '0;
            end else begin
                m_valid_d = pop;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + CW'(1);
            end
        end

        // FWFT keeps the RAM output tracking the next head; legacy only reads on a pop.
        if (FWFT == FWFT_ON) begin
            rd_en   = 1'b1;
            rd_addr = rd_ptr_d;
        end else begin
            rd_en   = pop;
            rd_addr = rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_valid_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_valid_q  <= m_valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fifo_sdp_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (push),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .re      (rd_en),
        .rd_addr (rd_addr),
        .rd_data (m_data)
    );

    assign m_valid  = m_valid_q;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: three configurations checked against a queue model.
module tb_stream_fifo;

    // Instance 0: FWFT, backpressure. 1: FWFT, drop-on-full, CW=2. 2: legacy read.
    logic       clk = 1'b0;
    logic       rst;
    logic       flush   [3];
    logic       s_valid [3];
    logic       m_ready [3];
    logic [7:0] s_data  [3];

    logic        s_ready      [3];
    logic        m_valid      [3];
    logic        full         [3];
    logic        empty        [3];
    logic        almost_full  [3];
    logic        almost_empty [3];
    logic [7:0]  m_data       [3];
    logic [2:0]  count        [3];
    logic [15:0] drop_cnt     [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Fw = (g == 2) ? 0 : 1;
        localparam int unsigned Dr = (g == 1) ? 1 : 0;
        localparam int unsigned Cw = (g == 1) ? 2 : 16;
        logic [Cw-1:0] dc;

        stream_fifo #(
            .W            (8),
            .DEPTH        (4),
            .FWFT         (Fw),
            .DROP_ON_FULL (Dr),
            .AF_TH        (3),
            .AE_TH        (1),
            .CW           (Cw)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush[g]),
            .s_data       (s_data[g]),
            .s_valid      (s_valid[g]),
            .s_ready      (s_ready[g]),
            .m_data       (m_data[g]),
            .m_valid      (m_valid[g]),
            .m_ready      (m_ready[g]),
            .count        (count[g]),
            .full         (full[g]),
            .empty        (empty[g]),
            .almost_full  (almost_full[g]),
            .almost_empty (almost_empty[g]),
            .drop_cnt     (dc)
        );

        assign drop_cnt[g] = 16'(dc);
    end

    int checks = 0;
    int errors = 0;

    // Model: contents with the edge number each word was written, plus expected outputs.
    int mq    [3][$];
    int mt    [3][$];
    bit mv    [3];
    int md    [3];
    bit mknown[3];
    int mdrop [3];
    int cyc      = 0;
    bit model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < 3; g++) begin
            bit fw   = (g != 2);
            bit dr   = (g == 1);
            int dmax = (g == 1) ? 3 : 65535;
            bit mfull;
            bit push;
            bit pop;
            int popped = 0;
            if (rst) begin
                mq[g].delete();
                mt[g].delete();
                mv[g]     = 1'b0;
                md[g]     = 0;
                mknown[g] = 1'b1;
                mdrop[g]  = 0;
            end else if (flush[g]) begin
                mq[g].delete();
                mt[g].delete();
                mv[g] = 1'b0;
                if (fw) mknown[g] = 1'b0;
            end else begin
                mfull = (mq[g].size() == 4);
                push  = s_valid[g] && !mfull;
                pop   = fw ? (mv[g] && m_ready[g]) : (m_ready[g] && mq[g].size() != 0);
                if (dr && s_valid[g] && mfull && mdrop[g] < dmax) mdrop[g]++;
                if (pop) begin
                    popped = mq[g].pop_front();
                    void'(mt[g].pop_front());
                end
                if (push) begin
                    mq[g].push_back(int'(s_data[g]));
                    mt[g].push_back(cyc);
                end
                if (fw) begin
                    // Head is shown only once it was written at an earlier edge.
                    mv[g]     = (mq[g].size() > 0) && (mt[g][0] < cyc);
                    mknown[g] = mv[g];
                    if (mv[g]) md[g] = mq[g][0];
                end else begin
                    mv[g] = pop;
                    if (pop) md[g] = popped;
                end
            end
        end
        cyc++;
        model_ok = 1'b1;
    endtask

    task automatic cmp_all();
        for (int g = 0; g < 3; g++) begin
            int sz = mq[g].size();
            bit dr = (g == 1);
            chk($sformatf("g%0d count", g), 32'(count[g]), sz);
            chk($sformatf("g%0d empty", g), 32'(empty[g]), 32'(sz == 0));
            chk($sformatf("g%0d full", g), 32'(full[g]), 32'(sz == 4));
            chk($sformatf("g%0d almost_full", g), 32'(almost_full[g]), 32'(sz >= 3));
            chk($sformatf("g%0d almost_empty", g), 32'(almost_empty[g]), 32'(sz <= 1));
            chk($sformatf("g%0d s_ready", g), 32'(s_ready[g]), 32'(!rst && (dr || sz < 4)));
            chk($sformatf("g%0d drop_cnt", g), 32'(drop_cnt[g]), mdrop[g]);
            chk($sformatf("g%0d m_valid", g), 32'(m_valid[g]), 32'(mv[g]));
            if (mknown[g]) chk($sformatf("g%0d m_data", g), 32'(m_data[g]), md[g]);
        end
    endtask

    // Compare at the falling edge, advance the model at the rising edge, drive after it.
    task automatic tick();
        @(negedge clk);
        if (model_ok) cmp_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [7:0] fill_v [4];

    initial begin
        fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            flush[g]   = 1'b0;
            s_valid[g] = 1'b0;
            m_ready[g] = 1'b0;
            s_data[g]  = 8'h00;
        end
        tick();
        tick();
        chk("reset count", 32'(count[0]), 0);
        chk("reset empty", 32'(empty[0]), 1);
        chk("reset s_ready low", 32'(s_ready[0]), 0);
        chk("reset m_data legacy", 32'(m_data[2]), 0);
        rst = 1'b0;
        #1;
        chk("s_ready after reset", 32'(s_ready[0]), 1);

        // Fill then drain, FWFT.
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = fill_v[i];
            tick();
            chk("fill almost_full", 32'(almost_full[0]), 32'(i >= 2));
        end
        chk("fill full", 32'(full[0]), 1);
        chk("fill s_ready", 32'(s_ready[0]), 0);
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain m_valid", 32'(m_valid[0]), 1);
            chk("drain order", 32'(m_data[0]), 32'(fill_v[i]));
            tick();
        end
        chk("drained empty", 32'(empty[0]), 1);
        chk("drained m_valid", 32'(m_valid[0]), 0);
        m_ready[0] = 1'b0;

        // Steady push+pop at count 2; twelve writes wrap the pointers three times.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h01;
        tick();
        s_data[0] = 8'h02;
        tick();
        m_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data[0] = 8'(8'hA0 + i);
            tick();
            chk("push+pop count", 32'(count[0]), 2);
        end
        chk("push+pop head", 32'(m_data[0]), 32'h00A8);
        s_valid[0] = 1'b0;
        tick();
        tick();
        m_ready[0] = 1'b0;
        chk("push+pop drained", 32'(count[0]), 0);

        // Drop-on-full with a 2-bit counter: 3 drops, then 5 more saturate.
        s_valid[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_data[1] = 8'(8'hD0 + i);
            tick();
        end
        chk("drop count 3", 32'(drop_cnt[1]), 3);
        chk("drop s_ready", 32'(s_ready[1]), 1);
        for (int i = 7; i < 12; i++) begin
            s_data[1] = 8'(8'hD0 + i);
            tick();
        end
        chk("drop saturated", 32'(drop_cnt[1]), 3);
        s_valid[1] = 1'b0;
        m_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drop kept words", 32'(m_data[1]), 32'(8'hD0 + i));
            tick();
        end
        m_ready[1] = 1'b0;
        chk("drop drained", 32'(empty[1]), 1);

        // Legacy registered read.
        s_valid[2] = 1'b1;
        s_data[2]  = 8'h5A;
        tick();
        s_valid[2] = 1'b0;
        m_ready[2] = 1'b1;
        tick();
        chk("legacy m_valid pulse", 32'(m_valid[2]), 1);
        chk("legacy m_data", 32'(m_data[2]), 32'h005A);
        m_ready[2] = 1'b0;
        tick();
        chk("legacy pulse ends", 32'(m_valid[2]), 0);
        m_ready[2] = 1'b1;
        tick();
        chk("legacy empty read", 32'(m_valid[2]), 0);
        m_ready[2] = 1'b0;
        tick();
        chk("legacy data held", 32'(m_data[2]), 32'h005A);

        // Flush with a concurrent push; drop_cnt on instance 1 must survive.
        s_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data[0] = 8'(8'h31 + i);
            tick();
        end
        s_data[0] = 8'h34;
        flush[0]  = 1'b1;
        flush[1]  = 1'b1;
        tick();
        flush[0] = 1'b0;
        flush[1] = 1'b0;
        chk("flush count", 32'(count[0]), 0);
        chk("flush empty", 32'(empty[0]), 1);
        chk("flush m_valid", 32'(m_valid[0]), 0);
        chk("flush keeps drop_cnt", 32'(drop_cnt[1]), 3);
        s_data[0] = 8'h35;
        tick();
        s_valid[0] = 1'b0;
        tick();
        chk("flushed word absent", 32'(m_data[0]), 32'h0035);
        chk("post-flush count", 32'(count[0]), 1);

        // Reset mid-stream.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h36;
        tick();
        s_valid[0] = 1'b0;
        chk("pre-reset count", 32'(count[0]), 2);
        rst = 1'b1;
        tick();
        chk("mid reset count", 32'(count[0]), 0);
        chk("mid reset drop_cnt", 32'(drop_cnt[1]), 0);
        chk("mid reset s_ready", 32'(s_ready[0]), 0);
        rst = 1'b0;
        #1;
        chk("post reset s_ready", 32'(s_ready[0]), 1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
